// File: rtl/reg_file_pkg.sv
// Shared defaults and reset image for the arbitrated register file.
// Also holds the request bundle type used around the port mux.
package reg_file_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_ADDR  = 4;

  localparam logic [7:0] REG_RST_VAL [16] = '{
    8'h00, 8'h00, 8'h81, 8'h20,
    8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00,
    8'h00, 8'h00, 8'h00, 8'h00
  };

  typedef struct packed {
    logic                 wr;
    logic                 rd;
    logic [DEF_ADDR-1:0]  addr;
    logic [DEF_WIDTH-1:0] wdata;
  } reg_req_t;

  function automatic logic [7:0] rst_val(input int i);
    if (i >= 0 && i < 16) return REG_RST_VAL[i];
    return 8'h00;
  endfunction

endpackage

// File: rtl/reg_file_arb_if.sv
// One register-file access port: request side plus
// grant and registered response side.
interface reg_file_arb_if
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ADDR  = DEF_ADDR
);
  logic             wr_en;
  logic             rd_en;
  logic [ADDR-1:0]  address;
  logic [WIDTH-1:0] wr_data;
  logic             ready;
  logic [WIDTH-1:0] rd_data;
  logic             rd_data_valid;
  logic             err;

  modport master (
    output wr_en, rd_en, address, wr_data,
    input  ready, rd_data, rd_data_valid, err
  );

  modport slave (
    input  wr_en, rd_en, address, wr_data,
    output ready, rd_data, rd_data_valid, err
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter, one-hot grant.
// Pointer only moves when both sides compete.
module rr_arb2
  import reg_file_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio_b;

  // pick a winner, alternating under contention
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b11:   gnt = prio_b ? 2'b10 : 2'b01;
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // remember who lost the last contended cycle
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      prio_b <= 1'b0;
    else if (&req)
      prio_b <= gnt[0];
  end

endmodule

// File: rtl/reg_file_arb.sv
// Dual-port register file with round-robin port arbitration,
// read-only mask, error pulses and exported low registers.
module reg_file_arb
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR     = DEF_ADDR,
  parameter int N_EXPORT = 4,
  parameter logic [DEPTH-1:0] RO_MASK = '0
)(
  input  logic                      CLK,
  input  logic                      RST,
  reg_file_arb_if.slave             A,
  reg_file_arb_if.slave             B,
  output logic [N_EXPORT*WIDTH-1:0] REGS
);

  logic [1:0]       req;
  logic [1:0]       gnt;
  reg_req_t         sel;
  logic             wr;
  logic             rd;
  logic [ADDR-1:0]  addr;
  logic [ADDR-1:0]  idx;
  logic [WIDTH-1:0] wdata;
  logic             in_rng;
  logic             ro;
  logic             bad;
  logic             do_wr;
  logic             do_rd;

  logic [WIDTH-1:0] regs    [DEPTH];
  logic [WIDTH-1:0] rdata_q [2];
  logic [1:0]       vld_q;
  logic [1:0]       err_q;

  assign req[0] = A.wr_en | A.rd_en;
  assign req[1] = B.wr_en | B.rd_en;

  rr_arb2 u_arb (
    .CLK (CLK),
    .RST (RST),
    .req (req),
    .gnt (gnt)
  );

  // mux the granted port and classify the access
  always_comb begin
    sel       = '0;
    sel.wr    = gnt[1] ? B.wr_en : A.wr_en;
    sel.rd    = gnt[1] ? B.rd_en : A.rd_en;
    wr        = sel.wr;
    rd        = sel.rd;
    addr      = gnt[1] ? B.address : A.address;
    wdata     = gnt[1] ? B.wr_data : A.wr_data;
    in_rng    = 32'(addr) < DEPTH;
    idx       = in_rng ? addr : '0;
    ro        = RO_MASK[idx];
    bad       = (wr & rd) | ~in_rng | (wr & ro);
    do_wr     = (|gnt) & wr & ~bad;
    do_rd     = rd & ~wr;
  end

  // storage, loaded with the reset image
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= WIDTH'(rst_val(i));
    end else if (do_wr) begin
      regs[idx] <= wdata;
    end
  end

  // per-port registered responses, one cycle after grant
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld_q      <= '0;
      err_q      <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        vld_q[p] <= gnt[p] & do_rd;
        err_q[p] <= gnt[p] & bad;
        if (gnt[p] & do_rd)
          rdata_q[p] <= in_rng ? regs[idx] : '0;
      end
    end
  end

  assign A.ready         = gnt[0] & RST;
  assign A.rd_data       = rdata_q[0];
  assign A.rd_data_valid = vld_q[0];
  assign A.err           = err_q[0];

  assign B.ready         = gnt[1] & RST;
  assign B.rd_data       = rdata_q[1];
  assign B.rd_data_valid = vld_q[1];
  assign B.err           = err_q[1];

  for (genvar g = 0; g < N_EXPORT; g++) begin : g_exp
    assign REGS[g*WIDTH +: WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_reg_file_arb.sv
// Directed bench for reg_file_arb: 12-entry file with
// register 2 read-only, both ports driven from one sequence.
module tb_reg_file_arb;
  import reg_file_pkg::*;

  logic        CLK;
  logic        RST;
  logic [31:0] REGS;
  int          n_cmp;
  int          n_bad;

  reg_file_arb_if #(.WIDTH(8), .ADDR(4)) a_if ();
  reg_file_arb_if #(.WIDTH(8), .ADDR(4)) b_if ();

  reg_file_arb #(
    .WIDTH    (8),
    .DEPTH    (12),
    .ADDR     (4),
    .N_EXPORT (4),
    .RO_MASK  (12'h004)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .A    (a_if.slave),
    .B    (b_if.slave),
    .REGS (REGS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    a_if.wr_en = 0; a_if.rd_en = 0;
    b_if.wr_en = 0; b_if.rd_en = 0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    RST = 0;
    idle();
    a_if.address = 0; a_if.wr_data = 0;
    b_if.address = 0; b_if.wr_data = 0;
    tick(); tick();
    a_if.rd_en = 1;
    #1;
    chk("rst_ready", {31'b0, a_if.ready}, 0);
    chk("rst_valid", {31'b0, a_if.rd_data_valid}, 0);
    idle();
    @(negedge CLK);
    RST = 1;
    tick();
    chk("rst_regs", REGS, 32'h2081_0000);
    chk("rst_a_ve", {30'b0, a_if.rd_data_valid, a_if.err}, 0);
    chk("rst_b_ve", {30'b0, b_if.rd_data_valid, b_if.err}, 0);

    // A write 0x5A to 5, then read it back
    a_if.wr_en = 1; a_if.address = 5; a_if.wr_data = 8'h5A;
    #1 chk("wr_ready", {31'b0, a_if.ready}, 1);
    tick();
    chk("wr_noresp", {30'b0, a_if.rd_data_valid, a_if.err}, 0);
    a_if.wr_en = 0; a_if.rd_en = 1;
    #1 chk("rd_ready", {31'b0, a_if.ready}, 1);
    tick();
    chk("rd_valid", {31'b0, a_if.rd_data_valid}, 1);
    chk("rd_data", {24'b0, a_if.rd_data}, 32'h5A);
    idle();
    tick();
    chk("rd_pulse", {31'b0, a_if.rd_data_valid}, 0);
    chk("rd_hold", {24'b0, a_if.rd_data}, 32'h5A);

    // contention: A reads 2, B reads 3, four cycles
    a_if.rd_en = 1; a_if.address = 2;
    b_if.rd_en = 1; b_if.address = 3;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_a", {31'b0, a_if.ready}, (i % 2 == 0) ? 1 : 0);
      chk("rr_b", {31'b0, b_if.ready}, (i % 2 == 1) ? 1 : 0);
      tick();
      if (i % 2 == 0) begin
        chk("rr_a_vld", {31'b0, a_if.rd_data_valid}, 1);
        chk("rr_a_dat", {24'b0, a_if.rd_data}, 32'h81);
      end else begin
        chk("rr_b_vld", {31'b0, b_if.rd_data_valid}, 1);
        chk("rr_b_dat", {24'b0, b_if.rd_data}, 32'h20);
      end
    end
    a_if.rd_en = 0;
    #1 chk("lone_b", {30'b0, a_if.ready, b_if.ready}, 32'h1);
    tick();
    a_if.rd_en = 1;
    #1 chk("rr_again", {30'b0, a_if.ready, b_if.ready}, 32'h2);
    tick();
    idle();

    // B writes read-only register 2
    b_if.wr_en = 1; b_if.address = 2; b_if.wr_data = 8'hFF;
    #1 chk("ro_ready", {31'b0, b_if.ready}, 1);
    tick();
    idle();
    chk("ro_err", {30'b0, b_if.err, b_if.rd_data_valid}, 32'h2);
    chk("ro_regs", REGS, 32'h2081_0000);
    a_if.wr_en = 1; a_if.address = 1; a_if.wr_data = 8'h33;
    tick();
    idle();
    chk("ro_errend", {31'b0, b_if.err}, 0);
    chk("wr1_regs", REGS, 32'h2081_3300);

    // out of range reads on a 12-deep file
    a_if.rd_en = 1; a_if.address = 14;
    tick();
    chk("oor14", {30'b0, a_if.err, a_if.rd_data_valid}, 32'h3);
    chk("oor14_d", {24'b0, a_if.rd_data}, 0);
    a_if.address = 12;
    tick();
    chk("oor12", {30'b0, a_if.err, a_if.rd_data_valid}, 32'h3);
    idle();

    // B writes 11, A reads it on the next grant
    b_if.wr_en = 1; b_if.address = 11; b_if.wr_data = 8'h77;
    tick();
    idle();
    a_if.rd_en = 1; a_if.address = 11;
    tick();
    idle();
    chk("raw_ve", {30'b0, a_if.err, a_if.rd_data_valid}, 32'h1);
    chk("raw_d", {24'b0, a_if.rd_data}, 32'h77);

    // write and read together is rejected
    a_if.wr_en = 1; a_if.rd_en = 1;
    a_if.address = 1; a_if.wr_data = 8'h99;
    #1 chk("wrrd_rdy", {31'b0, a_if.ready}, 1);
    tick();
    idle();
    chk("wrrd_ve", {30'b0, a_if.err, a_if.rd_data_valid}, 32'h2);
    chk("wrrd_regs", REGS, 32'h2081_3300);
    tick();
    chk("err_pulse", {31'b0, a_if.err}, 0);

    // reset lands between grant and response
    a_if.rd_en = 1; a_if.address = 1;
    #1 chk("rr_rdy", {31'b0, a_if.ready}, 1);
    #2 RST = 0;
    idle();
    #1;
    chk("rr_rst", {30'b0, a_if.ready, a_if.rd_data_valid}, 0);
    chk("rr_rdat", {24'b0, a_if.rd_data}, 0);
    tick();
    chk("rr_novld", {31'b0, a_if.rd_data_valid}, 0);
    chk("rr_regs", REGS, 32'h2081_0000);
    @(negedge CLK);
    RST = 1;
    tick();
    chk("post_rst", {30'b0, a_if.err, a_if.rd_data_valid}, 0);
    a_if.rd_en = 1; a_if.address = 3;
    tick();
    idle();
    chk("resume_v", {31'b0, a_if.rd_data_valid}, 1);
    chk("resume_d", {24'b0, a_if.rd_data}, 32'h20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
